// File: rtl/adat_i_frame_sync.sv
// ---------------------------------------------------------------------------
// adat_i_frame_sync
//
// Front end of the ADAT input path. NRZI-decodes 1..8 isochronous ADAT lines
// (one bit per clk), hunts for the 10-zero sync on stream 0, verifies it one
// frame later, and then flywheels the 256-bit frame position. While locked,
// every completed 10-bit group (1,nnnn,1,nnnn) of every stream is published
// on subframe_data, and the four user bits of each stream are latched once
// per frame.
//
// Optional feature: define ADAT_I_STREAM_CHECK_EN to enable per-stream
// framing checks reported on stream_err. Without it stream_err is tied low.
//
// Ports
//   clk            in   recovered bit clock, one ADAT bit per cycle
//   reset          in   synchronous, active-high
//   adat_in        in   raw NRZI line samples, bit s = stream s
//   subframe_data  out  10 bits/stream at [10s+9:10s], oldest bit at MSB
//   subframe_valid out  one-cycle pulse, subframe_data updated this cycle
//   frame_done     out  one-cycle pulse at each frame start while locked
//   user_bits      out  4 user bits/stream at [4s+3:4s], once per frame
//   locked         out  frame alignment valid
//   stream_err     out  per-stream framing error flags
// ---------------------------------------------------------------------------
module adat_i_frame_sync #(
    parameter int INPUT_STREAMS = 1,
    parameter int MISS_LIMIT    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INPUT_STREAMS-1:0] adat_in,
    output logic [79:0]              subframe_data,
    output logic                     subframe_valid,
    output logic                     frame_done,
    output logic [31:0]              user_bits,
    output logic                     locked,
    output logic [7:0]               stream_err
);

    localparam logic [1:0]  ST_HUNT     = 2'd0;
    localparam logic [1:0]  ST_VERIFY   = 2'd1;
    localparam logic [1:0]  ST_LOCKED   = 2'd2;
    localparam logic [10:0] SYNC_PAT    = 11'b000_0000_0001;
    localparam logic [7:0]  POS_SYNC    = 8'd10;
    localparam logic [7:0]  POS_REALIGN = 8'd11;
    localparam logic [7:0]  POS_USER    = 8'd15;
    localparam logic [2:0]  MISS_MAX    = 3'(MISS_LIMIT);

    logic [INPUT_STREAMS-1:0]       in_q, in_d;
    logic [INPUT_STREAMS-1:0]       in_dly_q, in_dly_d;
    logic [INPUT_STREAMS-1:0][10:0] sr_q, sr_d;
    logic [1:0]                     state_q, state_d;
    logic [7:0]                     pos_q, pos_d;
    logic [2:0]                     miss_q, miss_d;
    logic [79:0]                    subframe_data_q, subframe_data_d;
    logic                           subframe_valid_q, subframe_valid_d;
    logic                           frame_done_q, frame_done_d;
    logic [31:0]                    user_bits_q, user_bits_d;
    logic                           locked_q, locked_d;

    logic       sync_det;
    logic       at_sync_pos;
    logic       grp_end;
    logic       publish;
    logic [2:0] miss_inc;

    // True when pos is the last bit (25+10g) of one of the 24 audio groups.
    function automatic logic is_group_end(input logic [7:0] p);
        logic hit;
        hit = 1'b0;
        for (int g = 0; g < 24; g++) begin
            if (p == 8'(25 + 10 * g)) hit = 1'b1;
        end
        return hit;
    endfunction

    // NRZI decode: a line transition is a '1'.
    always_comb begin
        in_d     = adat_in;
        in_dly_d = in_q;
        sr_d     = sr_q;
        for (int s = 0; s < INPUT_STREAMS; s++) begin
            sr_d[s] = {sr_q[s][9:0], in_q[s] ^ in_dly_q[s]};
        end
    end

    // pos_q is the frame index of the newest bit held in sr.
    assign sync_det    = (sr_q[0] == SYNC_PAT);
    assign at_sync_pos = (pos_q == POS_SYNC);
    assign grp_end     = is_group_end(pos_q);
    assign publish     = (state_q == ST_LOCKED) && grp_end;
    assign miss_inc    = miss_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q + 8'd1;
        miss_d       = miss_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (sync_det) begin
                    state_d = ST_VERIFY;
                    pos_d   = POS_REALIGN;
                end
            end
            ST_VERIFY: begin
                if (sync_det && at_sync_pos) begin
                    // Second sync exactly one frame later: the frame starting
                    // now is the first one reported.
                    state_d      = ST_LOCKED;
                    miss_d       = 3'd0;
                    frame_done_d = 1'b1;
                end else if (sync_det) begin
                    pos_d = POS_REALIGN;
                end else if (at_sync_pos) begin
                    state_d = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                // Off-position syncs are ignored; only the expected slot counts.
                if (at_sync_pos) begin
                    if (sync_det) begin
                        miss_d       = 3'd0;
                        frame_done_d = 1'b1;
                    end else if (miss_inc == MISS_MAX) begin
                        state_d = ST_HUNT;
                        miss_d  = 3'd0;
                    end else begin
                        miss_d       = miss_inc;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    always_comb begin
        locked_d         = (state_d == ST_LOCKED);
        subframe_valid_d = publish;
        subframe_data_d  = subframe_data_q;
        user_bits_d      = user_bits_q;
        if (publish) begin
            for (int s = 0; s < INPUT_STREAMS; s++) begin
                subframe_data_d[10*s +: 10] = sr_q[s][9:0];
            end
        end
        // sr[4:1] hold frame bits 11..14 once bit 15 is newest.
        if ((state_q == ST_LOCKED) && (pos_q == POS_USER)) begin
            for (int s = 0; s < INPUT_STREAMS; s++) begin
                user_bits_d[4*s +: 4] = sr_q[s][4:1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q             <= '0;
            in_dly_q         <= '0;
            sr_q             <= '0;
            state_q          <= ST_HUNT;
            pos_q            <= 8'd0;
            miss_q           <= 3'd0;
            subframe_data_q  <= '0;
            subframe_valid_q <= 1'b0;
            frame_done_q     <= 1'b0;
            user_bits_q      <= '0;
            locked_q         <= 1'b0;
        end else begin
            in_q             <= in_d;
            in_dly_q         <= in_dly_d;
            sr_q             <= sr_d;
            state_q          <= state_d;
            pos_q            <= pos_d;
            miss_q           <= miss_d;
            subframe_data_q  <= subframe_data_d;
            subframe_valid_q <= subframe_valid_d;
            frame_done_q     <= frame_done_d;
            user_bits_q      <= user_bits_d;
            locked_q         <= locked_d;
        end
    end

`ifdef ADAT_I_STREAM_CHECK_EN
    logic [7:0] err_flag_q, err_flag_d;
    logic [7:0] stream_err_q, stream_err_d;
    logic [7:0] fail_vec;

    always_comb begin
        fail_vec = 8'h00;
        for (int s = 0; s < INPUT_STREAMS; s++) begin
            if (at_sync_pos && (sr_q[s] != SYNC_PAT)) fail_vec[s] = 1'b1;
            if ((pos_q == POS_USER) && !sr_q[s][0]) fail_vec[s] = 1'b1;
            if (grp_end && !(sr_q[s][9] && sr_q[s][4])) fail_vec[s] = 1'b1;
        end
        stream_err_d = stream_err_q;
        err_flag_d   = err_flag_q | fail_vec;
        // At a frame start the finished frame is reported and the new frame's
        // flag starts from its own sync check.
        if (frame_done_d) begin
            stream_err_d = err_flag_q;
            err_flag_d   = fail_vec;
        end
        if (state_d != ST_LOCKED) begin
            stream_err_d = 8'h00;
            err_flag_d   = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag_q   <= 8'h00;
            stream_err_q <= 8'h00;
        end else begin
            err_flag_q   <= err_flag_d;
            stream_err_q <= stream_err_d;
        end
    end

    assign stream_err = stream_err_q;
`else
    assign stream_err = 8'h00;
`endif

    assign subframe_data  = subframe_data_q;
    assign subframe_valid = subframe_valid_q;
    assign frame_done     = frame_done_q;
    assign user_bits      = user_bits_q;
    assign locked         = locked_q;

endmodule
